// File: rtl/ascon_linear_inv.sv
// Inverse of the Ascon linear diffusion layer, computed iteratively as L^63 = prod L^(2^k), k = 0..5.
// Define ASCON_LINV_UNROLL2_EN to apply two rounds per clock (latency 3 instead of 6).
module ascon_linear_inv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Forward-layer rotation pairs, word 0 in the least significant slot.
    localparam logic [4:0][5:0] ROT_A = {6'd7, 6'd10, 6'd1, 6'd61, 6'd19};
    localparam logic [4:0][5:0] ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

`ifdef ASCON_LINV_UNROLL2_EN
    localparam logic [2:0] LAST_RND = 3'd2;
`else
    localparam logic [2:0] LAST_RND = 3'd5;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       rnd;
    logic [2:0]       rnd_nxt;
    logic [4:0][63:0] st;
    logic [4:0][63:0] st_nxt;
    logic [4:0][63:0] rounded;
    logic [2:0]       k_lo;

    function automatic logic [63:0] rotr(input logic [63:0] v, input logic [5:0] r);
        logic [127:0] d;
        d = {v, v} >> r;
        return d[63:0];
    endfunction

    // One application of L^(2^k): squaring the diffusion polynomial doubles both rotations.
    function automatic logic [63:0] lin_pow(input logic [63:0] w, input logic [5:0] a,
                                            input logic [5:0] b, input logic [2:0] k);
        logic [5:0] ra;
        logic [5:0] rb;
        ra = a << k;
        rb = b << k;
        return w ^ rotr(w, ra) ^ rotr(w, rb);
    endfunction

`ifdef ASCON_LINV_UNROLL2_EN
    logic [2:0] k_hi;
    assign k_lo = {rnd[1:0], 1'b0};
    assign k_hi = {rnd[1:0], 1'b1};
`else
    assign k_lo = rnd;
`endif

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rounded[i] = lin_pow(st[i], ROT_A[i], ROT_B[i], k_lo);
`ifdef ASCON_LINV_UNROLL2_EN
            rounded[i] = lin_pow(rounded[i], ROT_A[i], ROT_B[i], k_hi);
`endif
        end
    end

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        rnd_nxt   = rnd;
        st_nxt    = st;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    st_nxt    = {x4, x3, x2, x1, x0};
                    rnd_nxt   = 3'd0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                st_nxt = rounded;
                if (rnd >= LAST_RND) begin
                    rnd_nxt   = 3'd0;
                    state_nxt = DONE;
                end else begin
                    rnd_nxt = rnd + 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                rnd_nxt   = 3'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: the state words are reset too, so y reads zero while and after reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rnd   <= 3'd0;
            st    <= '0;
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
            st    <= st_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY) || (state == DONE);

    assign y0 = st[0];
    assign y1 = st[1];
    assign y2 = st[2];
    assign y3 = st[3];
    assign y4 = st[4];

endmodule

// File: tb/tb_ascon_linear_inv.sv
// Scoreboard bench for ascon_linear_inv: inputs are forward-layer images of known states, outputs must recover them.
module tb_ascon_linear_inv;

`ifdef ASCON_LINV_UNROLL2_EN
    localparam int LAT = 3;
    localparam int MID = 1;
`else
    localparam int LAT = 6;
    localparam int MID = 3;
`endif
    localparam int THRU = LAT + 2;
    localparam int FA[5] = '{19, 61, 1, 10, 7};
    localparam int FB[5] = '{28, 39, 6, 17, 41};

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [4:0][63:0] xb = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [63:0]      y0, y1, y2, y3, y4;
    logic [4:0][63:0] yb;

    typedef struct {
        logic [4:0][63:0] y;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic prev_ov = 1'b0;

    ascon_linear_inv dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .x4(xb[4]),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .busy(busy)
    );

    assign yb = {y4, y3, y2, y1, y0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] rr(input logic [63:0] w, input int r);
        return (w >> r) | (w << (64 - r));
    endfunction

    function automatic logic [4:0][63:0] fwd(input logic [4:0][63:0] v);
        logic [4:0][63:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[i] ^ rr(v[i], FA[i]) ^ rr(v[i], FB[i]);
        return r;
    endfunction

    // Drives a state and holds in_valid until the accept edge; the caller drops in_valid.
    task automatic send(input logic [4:0][63:0] x, input logic [4:0][63:0] e, output int acc);
        int   budget;
        exp_t t;
        budget = 0;
        xb = x;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 200) begin
                $display("FAIL send_timeout: in_ready never rose within %0d cycles", budget);
                $fatal(1, "input handshake stalled");
            end
        end
        @(posedge clk); #1;
        acc = cyc;
        t.y = e;
        t.acc = cyc;
        sb.push_back(t);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || !in_ready) && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (!prev_ov) begin
                if (sb.size() == 0) check("unexpected_out_valid", 64'd1, 64'd0);
                else begin
                    check("latency", 64'(cyc - sb[0].acc), 64'(LAT));
                    check("busy_in_done", 64'(busy), 64'd1);
                end
            end
            if (out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 5; i++) check($sformatf("y%0d", i), yb[i], e.y[i]);
            end
        end
        prev_ov = rst_n && out_valid;
    end

    initial begin
        logic [4:0][63:0] v;
        logic [4:0][63:0] other;
        int acc;
        int accs[4];
        int budget;

        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) check($sformatf("rst_y%0d", i), yb[i], 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, accepted back to back starting on the first edge after reset.
        send('0, '0, acc);
        v = {5{64'hFFFF_FFFF_FFFF_FFFF}};
        send(v, v, acc);
        send({192'h0, 64'h0, 64'h0000_2010_0000_0001}, {256'h0, 64'h1}, acc);
        v = {64'h0, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF,
             64'h8000_0000_0000_0000, 64'h1};
        send(fwd(v), v, acc);
        in_valid = 1'b0;
        drain();

        // Backpressure: result held in DONE while a competing input is presented.
        out_ready = 1'b0;
        v = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC,
             64'hDDDD_EEEE_FFFF_0000, 64'h0F0F_F0F0_1234_5678};
        other = {5{64'hA5A5_5A5A_C3C3_3C3C}};
        send(fwd(v), v, acc);
        budget = 0;
        while (!out_valid && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("bp_out_valid_rose", 64'(out_valid), 64'd1);
        xb = fwd(other);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) check($sformatf("bp_y%0d", i), yb[i], v[i]);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            if (c == 15) in_valid = 1'b0;
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_popped", 64'(sb.size()), 64'd0);
        drain();

        // Reset in the middle of the round sequence.
        v = {5{64'h0123_4567_89AB_CDEF}};
        send(fwd(v), v, acc);
        in_valid = 1'b0;
        repeat (MID) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) check($sformatf("midrst_y%0d", i), yb[i], 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("midrst_no_output", 64'(out_valid), 64'd0);
        end
        v = {64'hCAFE_F00D_0000_0007, 64'h0, 64'h1, 64'h8000_0000_0000_0001, 64'hFEDC_BA98_7654_3210};
        send(fwd(v), v, acc);
        in_valid = 1'b0;
        drain();

        // Back to back with in_valid and out_ready held high.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 5; i++) v[i] = 64'h1 << (n * 13 + i * 7);
            send(fwd(v), v, accs[n]);
        end
        in_valid = 1'b0;
        for (int n = 1; n < 4; n++) check("b2b_spacing", 64'(accs[n] - accs[n-1]), 64'(THRU));
        drain();

        // Random round trips.
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 5; i++) v[i] = {$urandom, $urandom};
            send(fwd(v), v, acc);
        end
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ascon_linear_inv.md
ASCON_LINEAR_INV -- requirements
Module: ascon_linear_inv

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  input state x0..x4 is valid.
REQ-005 in_ready  output  1  block can accept a state; high only in IDLE.
REQ-006 x0, x1, x2, x3, x4  input  64 each  Ascon state words after the linear diffusion layer.
REQ-007 out_valid  output  1  y0..y4 hold the inverted state.
REQ-008 out_ready  input  1  consumer accepts y0..y4.
REQ-009 y0, y1, y2, y3, y4  output  64 each  recovered pre-diffusion state words, registered.
REQ-010 busy  output  1  high in BUSY and DONE.

Function
REQ-011 rot(v,r) SHALL denote a 64-bit right rotation by r, where r is taken mod 64, matching the forward diffusion layer.
REQ-012 Per-word rotation pairs (a,b) SHALL be: word0 (19,28), word1 (61,39), word2 (1,6), word3 (10,17), word4 (7,41).
REQ-013 Round k (k = 0..5) SHALL replace every word w with w ^ rot(w, (a<<k) mod 64) ^ rot(w, (b<<k) mod 64), using that word's own pair.
REQ-014 The six rounds compose to L^63 = L^-1 because L^64 = I; the block SHALL produce exactly the inverse of the forward layer for every input.
REQ-015 The FSM states SHALL be IDLE, BUSY and DONE.
REQ-016 IDLE: in_ready=1; when in_valid=1 at a clock edge, the block SHALL load x0..x4 into the state registers, clear the round counter and go to BUSY.
REQ-017 BUSY: the block SHALL apply one round per edge with a 3-bit counter rnd; after the edge that applies round 5 it SHALL go to DONE.
REQ-018 DONE: out_valid=1, and y0..y4 SHALL be held stable until out_ready=1; the edge that has out_ready=1 SHALL return the block to IDLE.
REQ-019 Latency: out_valid SHALL rise 6 edges after the accept edge; throughput is one state per 8 cycles when out_ready is held at 1.
REQ-020 in_valid and x0..x4 SHALL be ignored outside IDLE; no input is queued.
REQ-021 out_ready SHALL be ignored outside DONE.
REQ-022 The rnd counter SHALL never exceed 5; an illegal state encoding SHALL recover to IDLE.
REQ-023 y0..y4 SHALL be driven directly from the state registers, with no combinational path from the inputs.

Reset
REQ-024 When rst_n=0, the block SHALL immediately enter IDLE with rnd=0, state registers 0, in_ready=1 and out_valid=0.
REQ-025 Reset asserted mid-operation (in BUSY or DONE) SHALL discard the operation, and no out_valid pulse SHALL follow.
REQ-026 After rst_n deasserts, the block SHALL be able to accept an input on the first clock edge.

Configuration
REQ-027 With the macro ASCON_LINV_UNROLL2_EN defined, each BUSY edge SHALL apply rounds k and k+1 (k = 0, 2, 4), giving a latency of 3 edges and a 3-value rnd counter.
REQ-028 Without ASCON_LINV_UNROLL2_EN, the single-round datapath of REQ-017 and REQ-019 SHALL apply.
REQ-029 The function, handshake and reset behaviour SHALL be identical in both builds; only the latency differs.

Verification
REQ-030 Zero state: all x = 0 -> all y = 0, with out_valid high exactly 6 edges (3 with the macro) after acceptance.
REQ-031 All-ones state: all x = 0xFFFF_FFFF_FFFF_FFFF -> all y = 0xFFFF_FFFF_FFFF_FFFF.
REQ-032 Round trip: v = {x0=0x1, x1=0x8000_0000_0000_0000, x2=0x0123_4567_89AB_CDEF, x3=0xDEAD_BEEF_0000_0001, x4=0} is passed through the forward reference model and fed in -> y equals v; repeat with 1000 random states.
REQ-033 Backpressure: out_ready held at 0 for 20 cycles in DONE -> y stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-034 Reset mid-operation: rst_n pulsed low at round 3 -> out_valid=0, in_ready=1 immediately, y=0; the next accepted state is inverted correctly.
REQ-035 Back-to-back: 4 states with in_valid and out_ready held at 1 -> 4 correct results, 8 cycles apart.
